// File: rtl/prv32_div_unit.sv
// rtl/prv32_div_unit.sv - iterative radix-2 restoring divide/remainder unit
//
// Purpose: executes RISC-V DIV, DIVU, REM and REMU one quotient bit per cycle
// beside the ALU in the execute stage. o_busy stalls the front of the pipe;
// o_done pulses once with a registered o_result.
//
// Ports:
//   i_clk     clock, all state on rising edge
//   i_rst     synchronous active-high reset
//   i_start   request, sampled only while idle
//   i_flush   pipeline kill, aborts any operation without a done pulse
//   i_a       dividend (rs1)
//   i_b       divisor (rs2)
//   i_op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   o_busy    operation in progress (RUN or FIN)
//   o_done    one-cycle pulse, o_result valid
//   o_result  quotient or remainder, held until the next accepted start
//
// Optional feature: PRV32_DIV_EARLY_OUT_EN - divide-by-zero, signed overflow
// and |a| < |b| skip the iteration and finish one cycle after acceptance.

module prv32_div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_op,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_a;
  logic        r_op_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_b_zero;
  logic        r_ovf;
  logic        r_small;
  logic        r_done;
  logic [31:0] r_result;

  // Operand conditioning at acceptance
  logic        w_accept;
  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_small;
  logic        w_skip;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_signed = ~i_op[0];
  assign w_sa     = w_signed & i_a[31];
  assign w_sb     = w_signed & i_b[31];
  assign w_mag_a  = w_sa ? (32'd0 - i_a) : i_a;
  assign w_mag_b  = w_sb ? (32'd0 - i_b) : i_b;
  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = w_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // Magnitude compare; never true when b==0, so it cannot mask that case.
  assign w_small  = (w_mag_a < w_mag_b);

`ifdef PRV32_DIV_EARLY_OUT_EN
  assign w_skip = w_b_zero | w_ovf | w_small;
`else
  assign w_skip = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, subtract divisor magnitude.
  // Bit 33 of the trial is the borrow, i.e. the trial went negative.
  logic [33:0] w_shift;
  logic [33:0] w_trial;
  logic        w_fits;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {2'b00, r_dvs};
  assign w_fits  = ~w_trial[33];

  // Sign fix-up and RISC-V special cases, evaluated in FIN
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_quot;
  logic [31:0] w_remd;
  logic [31:0] w_fin_val;

  assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

  always_comb begin
    w_quot = w_q_fix;
    w_remd = w_r_fix;
    if (r_b_zero) begin
      w_quot = 32'hFFFF_FFFF;
      w_remd = r_a;
    end else if (r_ovf) begin
      w_quot = 32'h8000_0000;
      w_remd = 32'd0;
    end else if (r_small) begin
      // Iteration yields the same values; the override covers the skipped path.
      w_quot = 32'd0;
      w_remd = r_a;
    end
  end

  assign w_fin_val = r_op_rem ? w_remd : w_quot;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_skip ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == 5'd0) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_flush) begin
      w_next = S_IDLE;
    end
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= 5'd0;
      r_rem    <= 33'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_a      <= 32'd0;
      r_op_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_ovf    <= 1'b0;
      r_small  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= 5'd31;
      r_rem    <= 33'd0;
      r_quo    <= w_mag_a;
      r_dvs    <= w_mag_b;
      r_a      <= i_a;
      r_op_rem <= i_op[1];
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_b_zero <= w_b_zero;
      r_ovf    <= w_ovf;
      r_small  <= w_small;
    end else if (r_state == S_RUN) begin
      r_rem <= w_fits ? w_trial[32:0] : w_shift[32:0];
      r_quo <= {r_quo[30:0], w_fits};
      if (r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  // Result register and done pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_FIN) && !i_flush) begin
        r_done   <= 1'b1;
        r_result <= w_fin_val;
      end
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_prv32_div_unit.sv
// tb/tb_prv32_div_unit.sv - scoreboard testbench for prv32_div_unit

module tb_prv32_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        i_flush;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [1:0]  i_op;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  prv32_div_unit dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_flush  (i_flush),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference semantics of the RISC-V M extension
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef PRV32_DIV_EARLY_OUT_EN
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(posedge i_clk) begin
    #1;
    if (o_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        check("result", o_result, exp_q.pop_front());
      end
    end
  end

  // Called just after an edge; returns just after E0
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    i_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (!o_done && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    issue(op, a, b, exp, 1'b1);
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    wait_done(0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
    check({tag, "_busy_drop"}, 32'(o_busy), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int lat;
    n_tests  = 0;
    n_fail   = 0;
    last_exp = 32'd0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_a      = 32'd0;
    i_b      = 32'd0;
    i_op     = 2'd0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Directed cases, issued back to back (each start lands in the done cycle)
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5);
    do_op("divu_5_0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_op("divu_small", 2'b01, 32'd3, 32'd10, 32'd0);
    do_op("rem_small",  2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFD);
    do_op("divu_max",   2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Start while busy is ignored
    issue(2'b01, 32'd1000, 32'd3, 32'd333, 1'b1);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    i_start = 1'b1;
    i_a     = 32'd50;
    i_b     = 32'd5;
    i_op    = 2'b01;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(10, lat);
    check("ignored_start_lat", 32'(lat), 32'd33);
    last_exp = 32'd333;
    // Immediately restart in the done cycle
    do_op("b2b_after_ignore", 2'b11, 32'd1000, 32'd7, 32'd6);

    // Flush at E15
    issue(2'b01, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0);
    repeat (14) begin
      @(posedge i_clk);
      #1;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    check("flush_busy", 32'(o_busy), 32'd0);
    check("flush_done", 32'(o_done), 32'd0);
    repeat (40) begin
      @(posedge i_clk);
      #1;
    end
    check("flush_result_held", o_result, last_exp);
    do_op("after_flush", 2'b00, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6);

    // Reset at E20
    issue(2'b01, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0);
    repeat (19) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_result", o_result, 32'd0);
    repeat (40) begin
      @(posedge i_clk);
      #1;
    end
    last_exp = 32'd0;

    // Flush and start together: nothing accepted
    i_start = 1'b1;
    i_flush = 1'b1;
    i_a     = 32'd9;
    i_b     = 32'd3;
    i_op    = 2'b01;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_flush = 1'b0;
    check("flush_start_busy", 32'(o_busy), 32'd0);
    repeat (40) begin
      @(posedge i_clk);
      #1;
    end
    check("flush_start_result", o_result, 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rop;
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      rop = 2'(i % 4);
      do_op("rand", rop, ra, rb, ref_div(rop, ra, rb));
    end

    repeat (5) begin
      @(posedge i_clk);
      #1;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prv32_div_unit.md
# prv32_div_unit

Iterative 32-bit divide/remainder unit for the pipelined RISC-V core's execute stage, working beside `prv32_ALU`. It runs DIV, DIVU, REM and REMU as a radix-2 restoring divider, one quotient bit per cycle. It raises `busy` so the hazard unit can stall IF/ID/EX, then pulses `done` with a registered result that the EX result mux forwards in place of the ALU output.

## Interface
- Parameters: none; operand width fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  pipeline kill; aborts an in-flight operation.
- `a`  in  32  dividend (rs1).
- `b`  in  32  divisor (rs2).
- `op`  in  2  same encoding as ALU `alufn[1:0]` for the 110_xx group: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `busy`  out  1  high while an operation is in progress (RUN or FIN).
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  quotient or remainder; held until next accepted `start`.

## Operation
- States:
  - IDLE.
  - RUN: 5-bit counter `cnt` runs 31 down to 0.
  - FIN.
- IDLE + `start` (and no `flush`):
  - latch `op`, operand signs and operand magnitudes (signed ops take |a| and |b|; unsigned ops use the raw values);
  - clear partial remainder (33 bits), load quotient register with |a|, `cnt`=31, go to RUN.
- RUN, each cycle:
  - shift {rem,quo} left 1;
  - trial = rem − |b|; if non-negative, rem=trial and quo[0]=1;
  - when `cnt`==0 go to FIN, otherwise decrement.
- FIN:
  - apply signs: quotient negated if sign(a)≠sign(b); remainder takes sign of a;
  - select quotient or remainder by `op[1]`; register into `result`; pulse `done`; go to IDLE.
- Special cases override the computed value in FIN, per RISC-V:
  - b==0: quotient = 0xFFFFFFFF (all ops); remainder = a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- `start` while `busy` is ignored; no queuing.
- `flush` in any state: next state IDLE; `done` stays 0; `result` unchanged.
- `flush` and `start` in the same IDLE cycle: flush wins; nothing is accepted.
- `rst` has priority over everything:
  - state IDLE; `busy`=0, `done`=0, `result`=0, counter and datapath registers 0;
  - reset mid-operation discards the operation silently.

## Timing
- `start` sampled at edge E0. Then:
  - `busy`=1 from after E0 through E33;
  - RUN occupies edges E1–E32;
  - FIN is the cycle after E32; `done`=1 and `result` valid after edge E33 for exactly one cycle;
  - `busy` drops with the same edge that raises `done`.
- Earliest back-to-back `start` is in the `done` cycle, because the unit is in IDLE then.
- `done` never asserts twice for one accepted `start`.
- The unit does not register `a`/`b` after E0; upstream may change them freely once `busy` is high.

## Configuration
- `PRV32_DIV_EARLY_OUT_EN`
  - Defined: at acceptance, b==0 or the signed-overflow case skips RUN and goes straight to FIN. `done` follows after edge E1 (latency 1) with the special-case result. The same early exit applies when unsigned |a| < |b`|: quotient 0, remainder = a.
  - Undefined: every operation takes the full 33-cycle latency, with identical results.

## Test plan
- DIVU a=100, b=7, `start` at E0 → `busy` high E0–E33; `done` after E33; `result`=14. Repeat with REMU → 2.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (−3). REM with same operands → 0xFFFFFFFF (−1). REM a=7, b=−2 → 1.
- DIV a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Check latency 33 without the macro and 1 with it.
- `start` asserted again at E10 with different operands → ignored; single `done` after E33 with the original result. New `start` in the `done` cycle → accepted.
- `flush` at E15 → `busy` low after E15; no `done`; `result` keeps its previous value. Next `start` completes normally.
- `rst` at E20 mid-operation → all outputs 0 after E20; no `done` follows. Simultaneous `flush`+`start` in IDLE → nothing accepted.
